// File: rtl/rv32i_pkg.sv
// RV32I decode constants, opcode class enum and the opcode classifier.
package rv32i_pkg;

    localparam int unsigned XLEN_DEFAULT = 32;

    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_FENCE  = 7'b0001111;
    localparam logic [6:0] OPC_SYSTEM = 7'b1110011;

    typedef enum logic [3:0] {
        CLASS_NONE   = 4'd0,
        CLASS_LUI    = 4'd1,
        CLASS_AUIPC  = 4'd2,
        CLASS_JAL    = 4'd3,
        CLASS_JALR   = 4'd4,
        CLASS_BRANCH = 4'd5,
        CLASS_LOAD   = 4'd6,
        CLASS_STORE  = 4'd7,
        CLASS_OP_IMM = 4'd8,
        CLASS_OP     = 4'd9,
        CLASS_FENCE  = 4'd10,
        CLASS_SYSTEM = 4'd11
    } id_class_e;

    // Unrecognised opcodes map to CLASS_NONE, which callers treat as illegal.
    function automatic id_class_e opcode_class(input logic [6:0] opc);
        case (opc)
            OPC_LUI:    return CLASS_LUI;
            OPC_AUIPC:  return CLASS_AUIPC;
            OPC_JAL:    return CLASS_JAL;
            OPC_JALR:   return CLASS_JALR;
            OPC_BRANCH: return CLASS_BRANCH;
            OPC_LOAD:   return CLASS_LOAD;
            OPC_STORE:  return CLASS_STORE;
            OPC_OP_IMM: return CLASS_OP_IMM;
            OPC_OP:     return CLASS_OP;
            OPC_FENCE:  return CLASS_FENCE;
            OPC_SYSTEM: return CLASS_SYSTEM;
            default:    return CLASS_NONE;
        endcase
    endfunction

endpackage

// File: rtl/imm_gen.sv
// Combinational RV32I immediate generator: picks the I/S/B/U/J format from the opcode.
module imm_gen
    import rv32i_pkg::*;
#(
    parameter int unsigned XLEN = XLEN_DEFAULT
) (
    input  logic [31:0]     instr,
    output logic [XLEN-1:0] imm
);

    logic [30:0] low;
    logic        sign;

    // Build the low 31 bits per format; formats without an immediate yield zero with no sign.
    always_comb begin
        low  = '0;
        sign = 1'b0;
        case (opcode_class(instr[6:0]))
            CLASS_JALR, CLASS_LOAD, CLASS_OP_IMM, CLASS_SYSTEM: begin
                low  = {{20{instr[31]}}, instr[30:20]};
                sign = instr[31];
            end
            CLASS_STORE: begin
                low  = {{20{instr[31]}}, instr[30:25], instr[11:7]};
                sign = instr[31];
            end
            CLASS_BRANCH: begin
                low  = {{19{instr[31]}}, instr[7], instr[30:25], instr[11:8], 1'b0};
                sign = instr[31];
            end
            CLASS_LUI, CLASS_AUIPC: begin
                low  = {instr[30:12], 12'b0};
                sign = instr[31];
            end
            CLASS_JAL: begin
                low  = {{11{instr[31]}}, instr[19:12], instr[20], instr[30:21], 1'b0};
                sign = instr[31];
            end
            default: ;
        endcase
    end

    assign imm = {{(XLEN - 31){sign}}, low};

endmodule

// File: rtl/decode_stage.sv
// RV32I decode stage: register-file addressing, write-back bypass, load-use stall,
// immediate/class decode and the ID/EX pipeline register with valid/ready handshake.
module decode_stage
    import rv32i_pkg::*;
#(
    parameter int unsigned XLEN  = XLEN_DEFAULT,
    parameter int unsigned CNT_W = 16
) (
    input  logic             Clock,
    input  logic             Reset,
    input  logic             If_Valid,
    input  logic [31:0]      If_Instr,
    input  logic [XLEN-1:0]  If_PC,
    output logic             Id_Ready,
    output logic [4:0]       Rf_Read_Reg1,
    output logic [4:0]       Rf_Read_Reg2,
    input  logic [XLEN-1:0]  Rf_Read_Data1,
    input  logic [XLEN-1:0]  Rf_Read_Data2,
    input  logic             Wb_Write,
    input  logic [4:0]       Wb_Reg,
    input  logic [XLEN-1:0]  Wb_Data,
    input  logic             Haz_Load_Valid,
    input  logic [4:0]       Haz_Load_Rd,
    input  logic             Flush,
    input  logic             Ex_Ready,
    output logic             Id_Valid,
    output logic [XLEN-1:0]  Id_PC,
    output logic [XLEN-1:0]  Id_Rs1_Data,
    output logic [XLEN-1:0]  Id_Rs2_Data,
    output logic [XLEN-1:0]  Id_Imm,
    output logic [4:0]       Id_Rd,
    output logic [2:0]       Id_Funct3,
    output logic             Id_Funct7b5,
    output id_class_e        Id_Class,
    output logic             Id_Illegal,
    output logic [CNT_W-1:0] Bubble_Count
);

    logic [4:0]      rs1_addr, rs2_addr;
    id_class_e       instr_class;
    logic            uses_rs1, uses_rs2, writes_rd;
    logic [XLEN-1:0] imm, rs1_data, rs2_data;
    logic            stall, advance;

    logic             valid_q;
    logic [XLEN-1:0]  pc_q, rs1_data_q, rs2_data_q, imm_q;
    logic [4:0]       rd_q;
    logic [2:0]       funct3_q;
    logic             funct7b5_q, illegal_q;
    id_class_e        class_q;
    logic [CNT_W-1:0] bubble_q;

    // x0 reads as zero; a write landing on this edge wins over the stale register-file value.
    function automatic logic [XLEN-1:0] select_operand(
        input logic [4:0]      addr,
        input logic [XLEN-1:0] rf_data,
        input logic            wb_write,
        input logic [4:0]      wb_reg,
        input logic [XLEN-1:0] wb_data
    );
        if (addr == 5'd0) return '0;
        if (wb_write && wb_reg == addr) return wb_data;
        return rf_data;
    endfunction

    assign rs1_addr     = If_Instr[19:15];
    assign rs2_addr     = If_Instr[24:20];
    assign Rf_Read_Reg1 = rs1_addr;
    assign Rf_Read_Reg2 = rs2_addr;

    imm_gen #(
        .XLEN (XLEN)
    ) u_imm_gen (
        .instr (If_Instr),
        .imm   (imm)
    );

    // Classify the opcode and derive which register fields are live.
    always_comb begin
        instr_class = opcode_class(If_Instr[6:0]);
        uses_rs1    = 1'b0;
        uses_rs2    = 1'b0;
        writes_rd   = 1'b0;
        case (instr_class)
            CLASS_LUI, CLASS_AUIPC, CLASS_JAL, CLASS_SYSTEM: writes_rd = 1'b1;
            CLASS_JALR, CLASS_LOAD, CLASS_OP_IMM: begin
                uses_rs1  = 1'b1;
                writes_rd = 1'b1;
            end
            CLASS_BRANCH, CLASS_STORE: begin
                uses_rs1 = 1'b1;
                uses_rs2 = 1'b1;
            end
            CLASS_OP: begin
                uses_rs1  = 1'b1;
                uses_rs2  = 1'b1;
                writes_rd = 1'b1;
            end
            default: ;
        endcase
    end

    assign rs1_data = select_operand(rs1_addr, Rf_Read_Data1, Wb_Write, Wb_Reg, Wb_Data);
    assign rs2_data = select_operand(rs2_addr, Rf_Read_Data2, Wb_Write, Wb_Reg, Wb_Data);

    assign stall = If_Valid && Haz_Load_Valid && (Haz_Load_Rd != 5'd0) &&
                   ((uses_rs1 && rs1_addr == Haz_Load_Rd) ||
                    (uses_rs2 && rs2_addr == Haz_Load_Rd));
    assign advance = !valid_q || Ex_Ready;
    // A flush drops whatever is offered, so the handshake may always complete.
    assign Id_Ready = Flush || (advance && !stall);

    // ID/EX register: flush > bubble > load > drain > hold.
    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) begin
            valid_q    <= 1'b0;
            pc_q       <= '0;
            rs1_data_q <= '0;
            rs2_data_q <= '0;
            imm_q      <= '0;
            rd_q       <= '0;
            funct3_q   <= '0;
            funct7b5_q <= 1'b0;
            class_q    <= CLASS_NONE;
            illegal_q  <= 1'b0;
            bubble_q   <= '0;
        end else if (Flush) begin
            valid_q <= 1'b0;
        end else if (advance && stall) begin
            valid_q <= 1'b0;
            if (bubble_q != '1) bubble_q <= bubble_q + CNT_W'(1);
        end else if (advance && If_Valid) begin
            valid_q    <= 1'b1;
            pc_q       <= If_PC;
            rs1_data_q <= rs1_data;
            rs2_data_q <= rs2_data;
            imm_q      <= imm;
            rd_q       <= writes_rd ? If_Instr[11:7] : 5'd0;
            funct3_q   <= If_Instr[14:12];
            funct7b5_q <= If_Instr[30];
            class_q    <= instr_class;
            illegal_q  <= (instr_class == CLASS_NONE);
        end else if (advance) begin
            valid_q <= 1'b0;
        end
    end

    assign Id_Valid     = valid_q;
    assign Id_PC        = pc_q;
    assign Id_Rs1_Data  = rs1_data_q;
    assign Id_Rs2_Data  = rs2_data_q;
    assign Id_Imm       = imm_q;
    assign Id_Rd        = rd_q;
    assign Id_Funct3    = funct3_q;
    assign Id_Funct7b5  = funct7b5_q;
    assign Id_Class     = class_q;
    assign Id_Illegal   = illegal_q;
    assign Bubble_Count = bubble_q;

endmodule

// File: tb/tb_decode_stage.sv
// Directed bench for decode_stage: vector table plus stall, back-pressure, flush and reset sequences.
module tb_decode_stage;
    import rv32i_pkg::*;

    localparam int unsigned XLEN  = 32;
    localparam int unsigned CNT_W = 3;

    logic             clk;
    logic             Reset;
    logic             If_Valid;
    logic [31:0]      If_Instr;
    logic [XLEN-1:0]  If_PC;
    logic             Id_Ready;
    logic [4:0]       Rf_Read_Reg1, Rf_Read_Reg2;
    logic [XLEN-1:0]  Rf_Read_Data1, Rf_Read_Data2;
    logic             Wb_Write;
    logic [4:0]       Wb_Reg;
    logic [XLEN-1:0]  Wb_Data;
    logic             Haz_Load_Valid;
    logic [4:0]       Haz_Load_Rd;
    logic             Flush;
    logic             Ex_Ready;
    logic             Id_Valid;
    logic [XLEN-1:0]  Id_PC, Id_Rs1_Data, Id_Rs2_Data, Id_Imm;
    logic [4:0]       Id_Rd;
    logic [2:0]       Id_Funct3;
    logic             Id_Funct7b5;
    id_class_e        Id_Class;
    logic             Id_Illegal;
    logic [CNT_W-1:0] Bubble_Count;

    int checks = 0;
    int errors = 0;

    decode_stage #(
        .XLEN  (XLEN),
        .CNT_W (CNT_W)
    ) dut (
        .Clock          (clk),
        .Reset          (Reset),
        .If_Valid       (If_Valid),
        .If_Instr       (If_Instr),
        .If_PC          (If_PC),
        .Id_Ready       (Id_Ready),
        .Rf_Read_Reg1   (Rf_Read_Reg1),
        .Rf_Read_Reg2   (Rf_Read_Reg2),
        .Rf_Read_Data1  (Rf_Read_Data1),
        .Rf_Read_Data2  (Rf_Read_Data2),
        .Wb_Write       (Wb_Write),
        .Wb_Reg         (Wb_Reg),
        .Wb_Data        (Wb_Data),
        .Haz_Load_Valid (Haz_Load_Valid),
        .Haz_Load_Rd    (Haz_Load_Rd),
        .Flush          (Flush),
        .Ex_Ready       (Ex_Ready),
        .Id_Valid       (Id_Valid),
        .Id_PC          (Id_PC),
        .Id_Rs1_Data    (Id_Rs1_Data),
        .Id_Rs2_Data    (Id_Rs2_Data),
        .Id_Imm         (Id_Imm),
        .Id_Rd          (Id_Rd),
        .Id_Funct3      (Id_Funct3),
        .Id_Funct7b5    (Id_Funct7b5),
        .Id_Class       (Id_Class),
        .Id_Illegal     (Id_Illegal),
        .Bubble_Count   (Bubble_Count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] instr;
        logic [31:0] rd1;
        logic [31:0] rd2;
        logic        wb_w;
        logic [4:0]  wb_r;
        logic [31:0] wb_d;
        logic [31:0] e_rs1;
        logic [31:0] e_rs2;
        logic [31:0] e_imm;
        logic [4:0]  e_rd;
        logic [2:0]  e_f3;
        logic        e_f7;
        id_class_e   e_cls;
        logic        e_ill;
    } vec_t;

    localparam int NV = 14;
    vec_t vecs [NV];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    initial begin
        vecs[0]  = '{32'hFFD08293, 32'd10, 32'h7, 1'b0, 5'd0, 32'h0,
                     32'd10, 32'h7, 32'hFFFFFFFD, 5'd5, 3'd0, 1'b1, CLASS_OP_IMM, 1'b0};
        vecs[1]  = '{32'h002081B3, 32'h11, 32'h0, 1'b1, 5'd2, 32'h55,
                     32'h11, 32'h55, 32'h0, 5'd3, 3'd0, 1'b0, CLASS_OP, 1'b0};
        vecs[2]  = '{32'h002081B3, 32'h11, 32'h22, 1'b1, 5'd0, 32'h55,
                     32'h11, 32'h22, 32'h0, 5'd3, 3'd0, 1'b0, CLASS_OP, 1'b0};
        vecs[3]  = '{32'h000001B3, 32'h99, 32'h88, 1'b1, 5'd0, 32'h55,
                     32'h0, 32'h0, 32'h0, 5'd3, 3'd0, 1'b0, CLASS_OP, 1'b0};
        vecs[4]  = '{32'hFE208EE3, 32'h5, 32'h6, 1'b0, 5'd0, 32'h0,
                     32'h5, 32'h6, 32'hFFFFFFFC, 5'd0, 3'd0, 1'b1, CLASS_BRANCH, 1'b0};
        vecs[5]  = '{32'h001000EF, 32'h33, 32'h44, 1'b1, 5'd1, 32'hAB,
                     32'h0, 32'hAB, 32'h00000800, 5'd1, 3'd0, 1'b0, CLASS_JAL, 1'b0};
        vecs[6]  = '{32'h8000007F, 32'h1, 32'h2, 1'b0, 5'd0, 32'h0,
                     32'h0, 32'h0, 32'h0, 5'd0, 3'd0, 1'b0, CLASS_NONE, 1'b1};
        vecs[7]  = '{32'h123450B7, 32'h10, 32'h20, 1'b1, 5'd8, 32'hCAFE,
                     32'hCAFE, 32'h20, 32'h12345000, 5'd1, 3'd5, 1'b0, CLASS_LUI, 1'b0};
        vecs[8]  = '{32'hFE20AC23, 32'h100, 32'h200, 1'b0, 5'd0, 32'h0,
                     32'h100, 32'h200, 32'hFFFFFFF8, 5'd0, 3'd2, 1'b1, CLASS_STORE, 1'b0};
        vecs[9]  = '{32'h80000397, 32'h1, 32'h2, 1'b0, 5'd0, 32'h0,
                     32'h0, 32'h0, 32'h80000000, 5'd7, 3'd0, 1'b0, CLASS_AUIPC, 1'b0};
        vecs[10] = '{32'h004280E7, 32'h40, 32'h50, 1'b0, 5'd0, 32'h0,
                     32'h40, 32'h50, 32'h4, 5'd1, 3'd0, 1'b0, CLASS_JALR, 1'b0};
        vecs[11] = '{32'hFFF12303, 32'h77, 32'h88, 1'b0, 5'd0, 32'h0,
                     32'h77, 32'h88, 32'hFFFFFFFF, 5'd6, 3'd2, 1'b1, CLASS_LOAD, 1'b0};
        vecs[12] = '{32'h0000000F, 32'h1, 32'h2, 1'b0, 5'd0, 32'h0,
                     32'h0, 32'h0, 32'h0, 5'd0, 3'd0, 1'b0, CLASS_FENCE, 1'b0};
        vecs[13] = '{32'h00000073, 32'h1, 32'h2, 1'b0, 5'd0, 32'h0,
                     32'h0, 32'h0, 32'h0, 5'd0, 3'd0, 1'b0, CLASS_SYSTEM, 1'b0};

        Reset = 1'b0; If_Valid = 1'b0; If_Instr = '0; If_PC = '0;
        Rf_Read_Data1 = '0; Rf_Read_Data2 = '0;
        Wb_Write = 1'b0; Wb_Reg = '0; Wb_Data = '0;
        Haz_Load_Valid = 1'b0; Haz_Load_Rd = '0; Flush = 1'b0; Ex_Ready = 1'b1;

        // Reset state
        #1 Reset = 1'b1;
        #1;
        check("rst_valid", 32'(Id_Valid), 32'd0);
        check("rst_bubble", 32'(Bubble_Count), 32'd0);
        check("rst_class", 32'(Id_Class), 32'(CLASS_NONE));
        check("rst_imm", Id_Imm, 32'd0);
        repeat (2) @(negedge clk);
        Reset = 1'b0;
        #1 check("idle_ready", 32'(Id_Ready), 32'd1);
        @(posedge clk); #1 check("idle_valid", 32'(Id_Valid), 32'd0);

        // Back-to-back vector table
        for (int i = 0; i < NV; i++) begin
            @(negedge clk);
            If_Valid = 1'b1; If_Instr = vecs[i].instr; If_PC = 32'h1000 + 32'(i * 4);
            Rf_Read_Data1 = vecs[i].rd1; Rf_Read_Data2 = vecs[i].rd2;
            Wb_Write = vecs[i].wb_w; Wb_Reg = vecs[i].wb_r; Wb_Data = vecs[i].wb_d;
            #1;
            check($sformatf("v%0d_ready", i), 32'(Id_Ready), 32'd1);
            check($sformatf("v%0d_raddr1", i), 32'(Rf_Read_Reg1), 32'(vecs[i].instr[19:15]));
            check($sformatf("v%0d_raddr2", i), 32'(Rf_Read_Reg2), 32'(vecs[i].instr[24:20]));
            @(posedge clk); #1;
            check($sformatf("v%0d_valid", i), 32'(Id_Valid), 32'd1);
            check($sformatf("v%0d_pc", i), Id_PC, 32'h1000 + 32'(i * 4));
            check($sformatf("v%0d_rs1", i), Id_Rs1_Data, vecs[i].e_rs1);
            check($sformatf("v%0d_rs2", i), Id_Rs2_Data, vecs[i].e_rs2);
            check($sformatf("v%0d_imm", i), Id_Imm, vecs[i].e_imm);
            check($sformatf("v%0d_rd", i), 32'(Id_Rd), 32'(vecs[i].e_rd));
            check($sformatf("v%0d_f3", i), 32'(Id_Funct3), 32'(vecs[i].e_f3));
            check($sformatf("v%0d_f7b5", i), 32'(Id_Funct7b5), 32'(vecs[i].e_f7));
            check($sformatf("v%0d_class", i), 32'(Id_Class), 32'(vecs[i].e_cls));
            check($sformatf("v%0d_illegal", i), 32'(Id_Illegal), 32'(vecs[i].e_ill));
        end
        Wb_Write = 1'b0;

        // Load-use stall on rs1, then on rs2, then release
        @(negedge clk);
        If_Instr = 32'h002081B3; If_PC = 32'h2000; Haz_Load_Valid = 1'b1; Haz_Load_Rd = 5'd1;
        #1 check("stall1_ready", 32'(Id_Ready), 32'd0);
        @(posedge clk); #1;
        check("stall1_valid", 32'(Id_Valid), 32'd0);
        check("stall1_bubbles", 32'(Bubble_Count), 32'd1);
        @(negedge clk); Haz_Load_Rd = 5'd2;
        #1 check("stall2_ready", 32'(Id_Ready), 32'd0);
        @(posedge clk); #1 check("stall2_bubbles", 32'(Bubble_Count), 32'd2);
        @(negedge clk); Haz_Load_Valid = 1'b0;
        #1 check("unstall_ready", 32'(Id_Ready), 32'd1);
        @(posedge clk); #1;
        check("unstall_valid", 32'(Id_Valid), 32'd1);
        check("unstall_rd", 32'(Id_Rd), 32'd3);
        check("unstall_bubbles", 32'(Bubble_Count), 32'd2);

        // lui matches the hazard in its rs fields but reads no registers
        @(negedge clk);
        If_Instr = 32'h123450B7; Haz_Load_Valid = 1'b1; Haz_Load_Rd = 5'd8;
        #1 check("lui_haz_ready", 32'(Id_Ready), 32'd1);
        @(posedge clk); #1;
        check("lui_haz_valid", 32'(Id_Valid), 32'd1);
        check("lui_haz_class", 32'(Id_Class), 32'(CLASS_LUI));
        check("lui_haz_bubbles", 32'(Bubble_Count), 32'd2);

        // Back-pressure: fields hold for three cycles
        @(negedge clk);
        Haz_Load_Valid = 1'b0; Ex_Ready = 1'b0; If_Instr = 32'hFFD08293;
        Rf_Read_Data1 = 32'd10;
        for (int k = 0; k < 3; k++) begin
            #1 check($sformatf("bp%0d_ready", k), 32'(Id_Ready), 32'd0);
            @(posedge clk); #1;
            check($sformatf("bp%0d_valid", k), 32'(Id_Valid), 32'd1);
            check($sformatf("bp%0d_imm", k), Id_Imm, 32'h12345000);
            check($sformatf("bp%0d_rd", k), 32'(Id_Rd), 32'd1);
            @(negedge clk);
        end
        Ex_Ready = 1'b1;
        #1 check("bp_release_ready", 32'(Id_Ready), 32'd1);
        @(posedge clk); #1;
        check("bp_release_imm", Id_Imm, 32'hFFFFFFFD);
        check("bp_release_rd", 32'(Id_Rd), 32'd5);
        check("bp_release_rs1", Id_Rs1_Data, 32'd10);

        // Flush overrides a stall and back-pressure
        @(negedge clk);
        Flush = 1'b1; Ex_Ready = 1'b0; Haz_Load_Valid = 1'b1; Haz_Load_Rd = 5'd1;
        If_Instr = 32'h002081B3;
        #1 check("flush_ready", 32'(Id_Ready), 32'd1);
        @(posedge clk); #1;
        check("flush_valid", 32'(Id_Valid), 32'd0);
        check("flush_bubbles", 32'(Bubble_Count), 32'd2);

        // Bubble counter saturates at all-ones
        @(negedge clk); Flush = 1'b0; Ex_Ready = 1'b1;
        for (int k = 0; k < 7; k++) begin
            @(posedge clk); #1;
            check($sformatf("sat%0d_bubbles", k), 32'(Bubble_Count),
                  (k + 3 > 7) ? 32'd7 : 32'(k + 3));
        end

        // Issue one instruction, then reset asynchronously between edges
        @(negedge clk); Haz_Load_Valid = 1'b0; If_Instr = 32'hFFD08293;
        @(posedge clk); #1 check("pre_rst_valid", 32'(Id_Valid), 32'd1);
        @(negedge clk); #2 Reset = 1'b1;
        #1;
        check("async_rst_valid", 32'(Id_Valid), 32'd0);
        check("async_rst_bubbles", 32'(Bubble_Count), 32'd0);
        check("async_rst_class", 32'(Id_Class), 32'(CLASS_NONE));
        @(negedge clk); Reset = 1'b0; If_Valid = 1'b0;
        @(posedge clk); #1 check("post_rst_valid", 32'(Id_Valid), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
